inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: walks the program counter, requests words from
// program memory and holds each one for decode until it is consumed.
//
// Ports:
//   clk, reset (sync, active-low), run (fetch enable)
//   mem_req/mem_addr/mem_ack/mem_data : program memory read port
//   inst_reg/inst_valid               : instruction presented to decode
//   exec_done/jump/jump_addr/skip     : consumption and pc redirect
//   pc                                : current program counter
module inst_fetch #(
  parameter int PC_W = 13,
  parameter int INST_W = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data,
  output logic [INST_W-1:0] inst_reg,
  output logic              inst_valid,
  input  logic              exec_done,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_addr,
  input  logic              skip,
  output logic [PC_W-1:0]   pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Inputs that do not belong to the current state are simply
  // never looked at, so spurious pulses cannot move any state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        // run is ignored here: an issued request always completes
        if (mem_ack) begin
          inst_d  = mem_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (exec_done) begin
          state_d = run ? FETCH : IDLE;
          // jump wins over skip; sums wrap modulo 2^PC_W
          if (jump)      pc_d = jump_addr;
          else if (skip) pc_d = pc_q + PC_W'(2);
          else           pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = (state_q == FETCH);
  assign inst_valid = (state_q == HOLD);
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign inst_reg   = inst_q;

endmodule
